pic_window_ctrl: RTL and testbench
==================================

PIC_WINDOW_CTRL -- requirements
Module: pic_window_ctrl

Interface
REQ-001 SHALL have parameter PIC_W, default 355, picture width in pixels.
REQ-002 SHALL have parameter PIC_H, default 200, picture height in lines.
REQ-003 SHALL have parameter LAT, default 3, cycles from rom_addr register to processed pixel valid (ROM 1 + YCbCr stage 2); legal 1..8.
REQ-004 SHALL have port sys_clk  in  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port enable  in  1  controller run enable.
REQ-007 SHALL have port frame_start  in  1  one-cycle pulse at start of each LCD frame.
REQ-008 SHALL have port de  in  1  LCD data-enable for current screen_x/screen_y.
REQ-009 SHALL have ports screen_x, screen_y  in  11 each  current raster coordinates.
REQ-010 SHALL have ports cfg_valid in 1, cfg_x in 11, cfg_y in 11, cfg_ready out 1  picture-origin update handshake.
REQ-011 SHALL have port rom_en  out  1  ROM read strobe.
REQ-012 SHALL have port rom_addr  out  17  ROM word address.
REQ-013 SHALL have port win_valid  out  1  processed pixel at datapath output belongs to picture; else background selected.
REQ-014 SHALL have port frame_cnt  out  8  frames scanned since reset, wraps 255->0.

Function
REQ-015 SHALL implement states IDLE, ARM, SCAN; IDLE->ARM when enable=1; ARM->SCAN on frame_start; SCAN->SCAN on frame_start (frame_cnt+1); any state->IDLE when enable=0.
REQ-016 SHALL hold active origin (org_x, org_y) and a one-entry pending buffer; cfg transfer occurs when cfg_valid&&cfg_ready.
REQ-017 SHALL drive cfg_ready=1 when pending buffer empty, 0 when full.
REQ-018 SHALL load pending origin into active origin on frame_start (any state) and empty buffer same cycle; transfer coinciding with frame_start and empty buffer SHALL apply directly to that frame.
REQ-019 SHALL compute in_win = SCAN && de && screen_x in [org_x, org_x+PIC_W-1] && screen_y in [org_y, org_y+PIC_H-1], inclusive, sums in 12 bits so windows past 2047 clip, never wrap.
REQ-020 SHALL use an incrementing address counter (no multiplier): cleared to 0 on frame_start; when in_win, rom_addr<=counter and counter+1 next cycle.
REQ-021 SHALL saturate counter at PIC_W*PIC_H-1 (70999 default); no wrap within a frame.
REQ-022 SHALL register rom_en<=in_win, 1-cycle latency from inputs; rom_addr holds last value when rom_en=0.
REQ-023 SHALL drive win_valid = rom_en delayed LAT cycles via shift pipeline.
REQ-024 SHALL, on enable=0, drop rom_en next cycle and clear win_valid pipeline same edge; counter and origins retained; frame_cnt frozen.
REQ-025 SHALL ignore frame_start in IDLE except for REQ-018 origin load.

Reset
REQ-026 SHALL on rst=1 set state IDLE, rom_en=0, rom_addr=0, win_valid pipeline=0, frame_cnt=0, counter=0, org_x=org_y=0, pending empty (cfg_ready=1 first cycle after reset).
REQ-027 SHALL let rst override all other inputs including a simultaneous cfg transfer or frame_start.

Verification
REQ-028 Origin (0,0), enable=1, frame_start, full 800x480 raster -> rom_en high exactly 71000 cycles, rom_addr 0..70999 in order, win_valid mirrors rom_en 3 cycles later.
REQ-029 Origin (100,50): pixel (100,50) -> rom_addr 0; (454,50) -> 354; (455,50) -> rom_en=0; (100,51) -> 355; (99,50) and (100,249)/(100,250) -> in/out respectively.
REQ-030 cfg_valid with (200,100) mid-frame -> cfg_ready=0 next cycle, origin unchanged until next frame_start, then window at (200,100), cfg_ready=1.
REQ-031 cfg_valid coincident with frame_start, buffer empty -> new origin used for that frame.
REQ-032 Origin (1900,1900) -> clipped, no wrap; no rom_en at x<1900.
REQ-033 enable=0 mid-window, and separately rst=1 mid-frame -> rom_en=0 next cycle, win_valid=0, reset values per REQ-026, ARM waits for next frame_start.

Source files
------------

// File: rtl/pic_window_ctrl_if.sv
// pic_window_ctrl_if: picture-origin update handshake.
//   cfg_valid  - master offers a new origin (cfg_x, cfg_y)
//   cfg_x/y    - proposed picture origin, 11 bits each
//   cfg_ready  - slave can accept (its one-entry pending buffer is empty)
// A transfer happens on any rising clock edge where cfg_valid && cfg_ready.
interface pic_window_ctrl_if;
    logic        cfg_valid;
    logic [10:0] cfg_x;
    logic [10:0] cfg_y;
    logic        cfg_ready;

    modport master (output cfg_valid, cfg_x, cfg_y, input cfg_ready);
    modport slave  (input cfg_valid, cfg_x, cfg_y, output cfg_ready);
endinterface

// File: rtl/pic_window_ctrl.sv
// pic_window_ctrl: places a PIC_W x PIC_H picture on the LCD raster, issues
// row-major ROM reads for the pixels inside the picture and flags which
// processed pixels (LAT cycles later) belong to the picture.
//   sys_clk, rst     - clock and synchronous active-high reset
//   enable           - run enable; low forces IDLE and flushes the valid pipe
//   frame_start      - one-cycle pulse at the start of each LCD frame
//   de, screen_x/y   - raster data-enable and coordinates
//   cfg              - origin update handshake (slave side)
//   rom_en, rom_addr - ROM read strobe and word address
//   win_valid        - datapath output pixel belongs to the picture
//   frame_cnt        - frames scanned since reset, wraps 255->0
module pic_window_ctrl #(
    parameter int PIC_W = 355,
    parameter int PIC_H = 200,
    parameter int LAT   = 3
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             frame_start,
    input  logic             de,
    input  logic [10:0]      screen_x,
    input  logic [10:0]      screen_y,
    pic_window_ctrl_if.slave cfg,
    output logic             rom_en,
    output logic [16:0]      rom_addr,
    output logic             win_valid,
    output logic [7:0]       frame_cnt
);
    localparam logic [16:0] ADDR_MAX = 17'(PIC_W * PIC_H - 1);
    localparam logic [11:0] W_M1     = 12'(PIC_W - 1);
    localparam logic [11:0] H_M1     = 12'(PIC_H - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [10:0]    org_x, org_y;
    logic [10:0]    pend_x, pend_y;
    logic           pend_full;
    logic           cfg_xfer;
    logic           frame_clr, frame_inc;
    logic           in_win;
    logic [11:0]    x_end, y_end;
    logic [16:0]    addr_cnt, cnt_base;
    logic [LAT-1:0] pipe;

    assign cfg.cfg_ready = ~pend_full;
    assign cfg_xfer      = cfg.cfg_valid & ~pend_full;

    // ---------------- state machine ----------------
    always_ff @(posedge sys_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assigned first so every path drives state_nxt; no latch.
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = ARM;
            ARM:     if (frame_start) state_nxt = SCAN;
            SCAN:    state_nxt = SCAN;
            default: state_nxt = IDLE;
        endcase
        if (!enable) state_nxt = IDLE;
    end

    // ---------------- window decode ----------------
    // 12-bit ends: an origin near 2047 produces an end beyond the raster's
    // reach, so the window clips at the screen edge instead of wrapping to 0.
    assign x_end = {1'b0, org_x} + W_M1;
    assign y_end = {1'b0, org_y} + H_M1;

    assign in_win = enable && (state == SCAN) && de &&
                    (screen_x >= org_x) && ({1'b0, screen_x} <= x_end) &&
                    (screen_y >= org_y) && ({1'b0, screen_y} <= y_end);

    // frame_start in IDLE only moves the origin; it neither restarts nor counts.
    assign frame_clr = enable && frame_start && (state != IDLE);
    assign frame_inc = enable && frame_start && (state == SCAN);
    assign cnt_base  = frame_clr ? 17'd0 : addr_cnt;

    // ---------------- datapath registers ----------------
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            rom_en    <= 1'b0;
            rom_addr  <= 17'd0;
            addr_cnt  <= 17'd0;
            pipe      <= '0;
            frame_cnt <= 8'd0;
            org_x     <= 11'd0;
            org_y     <= 11'd0;
            pend_x    <= 11'd0;
            pend_y    <= 11'd0;
            pend_full <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            rom_en <= in_win;
            if (in_win) begin
                rom_addr <= cnt_base;
                addr_cnt <= (cnt_base == ADDR_MAX) ? cnt_base : cnt_base + 17'd1;
            end else begin
                addr_cnt <= cnt_base;
            end

            if (!enable) begin
                pipe <= '0;
            end else begin
                pipe[0] <= rom_en;
                for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
            end

            if (frame_inc) frame_cnt <= frame_cnt + 8'd1;

            // A buffered origin takes effect at frame_start. With the buffer empty,
            // an update accepted on the frame_start edge goes straight to active.
            if (frame_start) begin
                if (pend_full) begin
                    org_x     <= pend_x;
                    org_y     <= pend_y;
                    pend_full <= 1'b0;
                end else if (cfg_xfer) begin
                    org_x <= cfg.cfg_x;
                    org_y <= cfg.cfg_y;
                end
            end else if (cfg_xfer) begin
                pend_x    <= cfg.cfg_x;
                pend_y    <= cfg.cfg_y;
                pend_full <= 1'b1;
            end
        end
    end

    assign win_valid = pipe[LAT-1];
endmodule

// File: tb/tb_pic_window_ctrl.sv
// tb_pic_window_ctrl: self-checking bench for pic_window_ctrl. A behavioural
// model tracks the run mode, origin and pending update, and counts in-window
// pixels since frame start to predict every ROM address.
module tb_pic_window_ctrl;
    localparam int PIC_W    = 355;
    localparam int PIC_H    = 200;
    localparam int LAT      = 3;
    localparam int ADDR_MAX = PIC_W * PIC_H - 1;

    logic        sys_clk = 1'b0;
    logic        rst, enable, frame_start, de;
    logic [10:0] screen_x, screen_y;
    logic        rom_en, win_valid;
    logic [16:0] rom_addr;
    logic [7:0]  frame_cnt;

    pic_window_ctrl_if cfg_if ();

    pic_window_ctrl #(.PIC_W(PIC_W), .PIC_H(PIC_H), .LAT(LAT)) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .enable      (enable),
        .frame_start (frame_start),
        .de          (de),
        .screen_x    (screen_x),
        .screen_y    (screen_y),
        .cfg         (cfg_if),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .win_valid   (win_valid),
        .frame_cnt   (frame_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int passes = 0;

    // ---------------- behavioural model ----------------
    typedef struct { int x; int y; } org_t;
    org_t pend_q[$];
    bit   m_armed, m_scanning;
    int   m_ox, m_oy, m_count;
    bit   e_rom_en, e_ready, e_win;
    int   e_addr, e_fcnt;
    int   cyc = 0;
    int   last_clear = 0;
    bit   rom_hist[4];

    // Apply one rising edge to the model using the inputs currently driven,
    // then sample 1 ns later.
    task automatic step();
        bit   hit, xfer;
        org_t p;
        @(posedge sys_clk);
        cyc++;
        if (rst) begin
            m_armed = 0; m_scanning = 0; m_ox = 0; m_oy = 0; m_count = 0;
            pend_q.delete();
            e_rom_en = 0; e_addr = 0; e_fcnt = 0; last_clear = cyc;
        end else begin
            xfer = cfg_if.cfg_valid && (pend_q.size() == 0);
            if (enable && (m_armed || m_scanning) && frame_start) m_count = 0;
            hit = enable && m_scanning && de &&
                  int'(screen_x) >= m_ox && int'(screen_x) <= m_ox + PIC_W - 1 &&
                  int'(screen_y) >= m_oy && int'(screen_y) <= m_oy + PIC_H - 1;
            e_rom_en = hit;
            if (hit) begin
                e_addr = m_count;
                if (m_count < ADDR_MAX) m_count++;
            end
            if (!enable) begin
                last_clear = cyc;
                m_armed = 0; m_scanning = 0;
            end else if (m_scanning) begin
                if (frame_start) e_fcnt = (e_fcnt + 1) % 256;
            end else if (m_armed) begin
                if (frame_start) begin m_armed = 0; m_scanning = 1; end
            end else begin
                m_armed = 1;
            end
            if (frame_start) begin
                if (pend_q.size() != 0) begin
                    p = pend_q.pop_front(); m_ox = p.x; m_oy = p.y;
                end else if (xfer) begin
                    m_ox = int'(cfg_if.cfg_x); m_oy = int'(cfg_if.cfg_y);
                end
            end else if (xfer) begin
                p.x = int'(cfg_if.cfg_x); p.y = int'(cfg_if.cfg_y);
                pend_q.push_back(p);
            end
        end
        e_ready = (pend_q.size() == 0);
        rom_hist[cyc % 4] = e_rom_en;
        // A processed pixel is valid LAT cycles after its read unless the
        // pipe was flushed during that time.
        e_win = (cyc >= LAT) && (cyc - last_clear >= LAT) && rom_hist[(cyc - LAT) % 4];
        #1;
    endtask

    task automatic idle_inputs();
        de = 0; frame_start = 0; cfg_if.cfg_valid = 0;
    endtask

    task automatic pix(int x, int y, bit d);
        screen_x = 11'(x); screen_y = 11'(y); de = d;
        step();
    endtask

    task automatic pulse_frame();
        de = 0; frame_start = 1; step(); frame_start = 0;
    endtask

    task automatic send_cfg(int x, int y);
        cfg_if.cfg_valid = 1; cfg_if.cfg_x = 11'(x); cfg_if.cfg_y = 11'(y);
        de = 0; step(); cfg_if.cfg_valid = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1; enable = 1; frame_start = 1; de = 1; screen_x = 0; screen_y = 0;
        cfg_if.cfg_valid = 1; cfg_if.cfg_x = 11'd7; cfg_if.cfg_y = 11'd7;
        step(); step();
        checks++; if (rom_en !== 1'b0) $display("FAIL reset_rom_en: got %0b want 0", rom_en); else passes++;
        checks++; if (rom_addr !== 17'd0) $display("FAIL reset_rom_addr: got %0d want 0", rom_addr); else passes++;
        checks++; if (win_valid !== 1'b0) $display("FAIL reset_win_valid: got %0b want 0", win_valid); else passes++;
        checks++; if (frame_cnt !== 8'd0) $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt); else passes++;
        checks++; if (cfg_if.cfg_ready !== 1'b1) $display("FAIL reset_cfg_ready: got %0b want 1", cfg_if.cfg_ready); else passes++;
        rst = 0; enable = 0; idle_inputs();
        step();
        checks++; if (cfg_if.cfg_ready !== 1'b1) $display("FAIL post_reset_cfg_ready: got %0b want 1", cfg_if.cfg_ready); else passes++;
    endtask

    task automatic test_full_frame();
        int en_seen = 0, win_seen = 0, last_addr = -1, want;
        enable = 1; idle_inputs();
        step();
        pulse_frame();
        for (int y = 0; y <= PIC_H; y++) begin
            for (int x = 0; x <= PIC_W; x++) begin
                pix(x, y, 1);
                if (rom_en === 1'b1) begin en_seen++; last_addr = int'(rom_addr); end
                if (win_valid === 1'b1) win_seen++;
                checks++;
                if (rom_en !== e_rom_en)
                    $display("FAIL full_rom_en (%0d,%0d): got %0b want %0b", x, y, rom_en, e_rom_en);
                else passes++;
                if (e_rom_en) begin
                    want = y * PIC_W + x;
                    checks++;
                    if (rom_addr !== 17'(want))
                        $display("FAIL full_rom_addr (%0d,%0d): got %0d want %0d", x, y, rom_addr, want);
                    else passes++;
                end
                checks++;
                if (win_valid !== e_win)
                    $display("FAIL full_win_valid (%0d,%0d): got %0b want %0b", x, y, win_valid, e_win);
                else passes++;
            end
        end
        for (int i = 0; i < LAT + 1; i++) begin
            pix(0, 0, 0);
            if (win_valid === 1'b1) win_seen++;
        end
        checks++; if (en_seen != PIC_W * PIC_H) $display("FAIL full_rom_en_count: got %0d want %0d", en_seen, PIC_W * PIC_H); else passes++;
        checks++; if (win_seen != PIC_W * PIC_H) $display("FAIL full_win_count: got %0d want %0d", win_seen, PIC_W * PIC_H); else passes++;
        checks++; if (last_addr != ADDR_MAX) $display("FAIL full_last_addr: got %0d want %0d", last_addr, ADDR_MAX); else passes++;
        pix(5, 5, 1);
        checks++; if (rom_en !== 1'b1 || rom_addr !== 17'(ADDR_MAX)) $display("FAIL saturate: got en=%0b addr=%0d want en=1 addr=%0d", rom_en, rom_addr, ADDR_MAX); else passes++;
        pix(0, 0, 0);
        checks++; if (rom_addr !== 17'(ADDR_MAX)) $display("FAIL addr_hold: got %0d want %0d", rom_addr, ADDR_MAX); else passes++;
    endtask

    task automatic test_points();
        send_cfg(100, 50);
        checks++; if (cfg_if.cfg_ready !== 1'b0) $display("FAIL points_ready_full: got %0b want 0", cfg_if.cfg_ready); else passes++;
        pulse_frame();
        checks++; if (cfg_if.cfg_ready !== 1'b1) $display("FAIL points_ready_empty: got %0b want 1", cfg_if.cfg_ready); else passes++;
        checks++; if (frame_cnt !== 8'(e_fcnt)) $display("FAIL points_frame_cnt: got %0d want %0d", frame_cnt, e_fcnt); else passes++;
        for (int x = 99; x <= 455; x++) begin
            pix(x, 50, 1);
            checks++;
            if (rom_en !== e_rom_en || (e_rom_en && rom_addr !== 17'(e_addr)))
                $display("FAIL points_row50 x=%0d: got en=%0b addr=%0d want en=%0b addr=%0d", x, rom_en, rom_addr, e_rom_en, e_addr);
            else passes++;
            if (x == 99 || x == 455) begin
                checks++; if (rom_en !== 1'b0) $display("FAIL points_edge_out x=%0d: got %0b want 0", x, rom_en); else passes++;
            end
            if (x == 100) begin
                checks++; if (rom_en !== 1'b1 || rom_addr !== 17'd0) $display("FAIL points_first: got en=%0b addr=%0d want en=1 addr=0", rom_en, rom_addr); else passes++;
            end
            if (x == 454) begin
                checks++; if (rom_en !== 1'b1 || rom_addr !== 17'd354) $display("FAIL points_last_col: got en=%0b addr=%0d want en=1 addr=354", rom_en, rom_addr); else passes++;
            end
        end
        pix(100, 51, 1);
        checks++; if (rom_en !== 1'b1 || rom_addr !== 17'd355) $display("FAIL points_row51: got en=%0b addr=%0d want en=1 addr=355", rom_en, rom_addr); else passes++;
        pix(100, 249, 1);
        checks++; if (rom_en !== 1'b1) $display("FAIL points_last_row: got %0b want 1", rom_en); else passes++;
        pix(100, 250, 1);
        checks++; if (rom_en !== 1'b0) $display("FAIL points_below: got %0b want 0", rom_en); else passes++;
        pix(99, 100, 1);
        checks++; if (rom_en !== 1'b0) $display("FAIL points_left: got %0b want 0", rom_en); else passes++;
    endtask

    task automatic test_cfg_midframe();
        send_cfg(200, 100);
        checks++; if (cfg_if.cfg_ready !== 1'b0) $display("FAIL mid_ready_full: got %0b want 0", cfg_if.cfg_ready); else passes++;
        // Offered while full: must be ignored.
        cfg_if.cfg_valid = 1; cfg_if.cfg_x = 11'd900; cfg_if.cfg_y = 11'd900;
        pix(0, 0, 0);
        cfg_if.cfg_valid = 0;
        pix(460, 120, 1);
        checks++; if (rom_en !== 1'b0) $display("FAIL mid_old_origin_out: got %0b want 0", rom_en); else passes++;
        pix(120, 60, 1);
        checks++; if (rom_en !== 1'b1) $display("FAIL mid_old_origin_in: got %0b want 1", rom_en); else passes++;
        pulse_frame();
        checks++; if (cfg_if.cfg_ready !== 1'b1) $display("FAIL mid_ready_after: got %0b want 1", cfg_if.cfg_ready); else passes++;
        pix(200, 100, 1);
        checks++; if (rom_en !== 1'b1 || rom_addr !== 17'd0) $display("FAIL mid_new_origin: got en=%0b addr=%0d want en=1 addr=0", rom_en, rom_addr); else passes++;
        pix(460, 120, 1);
        checks++; if (rom_en !== 1'b1 || rom_addr !== 17'(e_addr)) $display("FAIL mid_new_inside: got en=%0b addr=%0d want en=1 addr=%0d", rom_en, rom_addr, e_addr); else passes++;
        pix(199, 100, 1);
        checks++; if (rom_en !== 1'b0) $display("FAIL mid_new_left: got %0b want 0", rom_en); else passes++;
    endtask

    task automatic test_cfg_coincident();
        cfg_if.cfg_valid = 1; cfg_if.cfg_x = 11'd300; cfg_if.cfg_y = 11'd10;
        pulse_frame();
        cfg_if.cfg_valid = 0;
        checks++; if (cfg_if.cfg_ready !== 1'b1) $display("FAIL coinc_ready: got %0b want 1", cfg_if.cfg_ready); else passes++;
        pix(300, 10, 1);
        checks++; if (rom_en !== 1'b1 || rom_addr !== 17'd0) $display("FAIL coinc_origin: got en=%0b addr=%0d want en=1 addr=0", rom_en, rom_addr); else passes++;
        pix(250, 100, 1);
        checks++; if (rom_en !== 1'b0) $display("FAIL coinc_old_area: got %0b want 0", rom_en); else passes++;
    endtask

    task automatic test_clip();
        send_cfg(1900, 1900);
        pulse_frame();
        for (int x = 1890; x <= 2047; x++) begin
            pix(x, 1900, 1);
            checks++;
            if (rom_en !== (x >= 1900) || rom_en !== e_rom_en || (e_rom_en && rom_addr !== 17'(e_addr)))
                $display("FAIL clip x=%0d: got en=%0b addr=%0d want en=%0b addr=%0d", x, rom_en, rom_addr, e_rom_en, e_addr);
            else passes++;
        end
        for (int x = 0; x <= 20; x++) begin
            pix(x, 1900, 1);
            checks++; if (rom_en !== 1'b0) $display("FAIL clip_wrap_x x=%0d: got %0b want 0", x, rom_en); else passes++;
        end
        for (int y = 0; y <= 10; y++) begin
            pix(1950, y, 1);
            checks++; if (rom_en !== 1'b0) $display("FAIL clip_wrap_y y=%0d: got %0b want 0", y, rom_en); else passes++;
        end
    endtask

    task automatic test_enable_drop();
        int fcnt_before;
        send_cfg(10, 10);
        pulse_frame();
        pix(10, 10, 1);
        pix(11, 10, 1);
        checks++; if (rom_en !== 1'b1) $display("FAIL drop_pre_en: got %0b want 1", rom_en); else passes++;
        fcnt_before = int'(frame_cnt);
        enable = 0;
        pix(12, 10, 1);
        checks++; if (rom_en !== 1'b0) $display("FAIL drop_rom_en: got %0b want 0", rom_en); else passes++;
        checks++; if (win_valid !== 1'b0) $display("FAIL drop_win_valid: got %0b want 0", win_valid); else passes++;
        // While disabled an accepted origin still loads at frame_start.
        send_cfg(20, 20);
        pulse_frame();
        for (int i = 0; i < LAT + 1; i++) begin
            pix(25, 25, 1);
            checks++; if (rom_en !== 1'b0 || win_valid !== 1'b0) $display("FAIL drop_idle i=%0d: got en=%0b wv=%0b want 0/0", i, rom_en, win_valid); else passes++;
        end
        checks++; if (int'(frame_cnt) != fcnt_before) $display("FAIL drop_frame_cnt: got %0d want %0d", frame_cnt, fcnt_before); else passes++;
        enable = 1;
        pix(20, 20, 1);
        pix(21, 20, 1);
        checks++; if (rom_en !== 1'b0) $display("FAIL drop_arm_waits: got %0b want 0", rom_en); else passes++;
        pulse_frame();
        pix(20, 20, 1);
        checks++; if (rom_en !== 1'b1 || rom_addr !== 17'd0) $display("FAIL drop_rearm: got en=%0b addr=%0d want en=1 addr=0", rom_en, rom_addr); else passes++;
        pix(19, 20, 1);
        checks++; if (rom_en !== 1'b0) $display("FAIL drop_new_origin_left: got %0b want 0", rom_en); else passes++;
    endtask

    task automatic test_reset_midframe();
        for (int x = 20; x < 30; x++) pix(x, 21, 1);
        rst = 1; frame_start = 1; de = 1;
        cfg_if.cfg_valid = 1; cfg_if.cfg_x = 11'd50; cfg_if.cfg_y = 11'd50;
        step();
        rst = 0; idle_inputs();
        checks++; if (rom_en !== 1'b0) $display("FAIL rstmid_rom_en: got %0b want 0", rom_en); else passes++;
        checks++; if (win_valid !== 1'b0) $display("FAIL rstmid_win_valid: got %0b want 0", win_valid); else passes++;
        checks++; if (rom_addr !== 17'd0) $display("FAIL rstmid_rom_addr: got %0d want 0", rom_addr); else passes++;
        checks++; if (frame_cnt !== 8'd0) $display("FAIL rstmid_frame_cnt: got %0d want 0", frame_cnt); else passes++;
        checks++; if (cfg_if.cfg_ready !== 1'b1) $display("FAIL rstmid_cfg_ready: got %0b want 1", cfg_if.cfg_ready); else passes++;
        pix(0, 0, 1);
        pix(1, 0, 1);
        checks++; if (rom_en !== 1'b0) $display("FAIL rstmid_arm_waits: got %0b want 0", rom_en); else passes++;
        pulse_frame();
        pix(0, 0, 1);
        checks++; if (rom_en !== 1'b1 || rom_addr !== 17'd0) $display("FAIL rstmid_origin_zero: got en=%0b addr=%0d want en=1 addr=0", rom_en, rom_addr); else passes++;
    endtask

    task automatic test_random();
        int errs = 0;
        rst = 0; enable = 1; idle_inputs();
        for (int n = 0; n < 6000; n++) begin
            rst = ($urandom_range(2999) == 0);
            if (enable) enable = ($urandom_range(499) != 0);
            else        enable = ($urandom_range(19) == 0);
            frame_start = ($urandom_range(299) == 0);
            cfg_if.cfg_valid = ($urandom_range(19) == 0);
            cfg_if.cfg_x = 11'($urandom_range(200));
            cfg_if.cfg_y = 11'($urandom_range(150));
            screen_x = 11'($urandom_range(600));
            screen_y = 11'($urandom_range(400));
            de = !frame_start && ($urandom_range(3) != 0);
            step();
            checks++;
            if (rom_en !== e_rom_en || rom_addr !== 17'(e_addr) || win_valid !== e_win ||
                cfg_if.cfg_ready !== e_ready || frame_cnt !== 8'(e_fcnt)) begin
                if (errs < 10)
                    $display("FAIL random n=%0d: got en=%0b addr=%0d wv=%0b rdy=%0b fc=%0d want en=%0b addr=%0d wv=%0b rdy=%0b fc=%0d",
                             n, rom_en, rom_addr, win_valid, cfg_if.cfg_ready, frame_cnt,
                             e_rom_en, e_addr, e_win, e_ready, e_fcnt);
                errs++;
            end else passes++;
        end
        rst = 0; idle_inputs();
    endtask

    initial begin
        rst = 1; enable = 0; frame_start = 0; de = 0; screen_x = 0; screen_y = 0;
        cfg_if.cfg_valid = 0; cfg_if.cfg_x = 0; cfg_if.cfg_y = 0;
        test_reset();
        test_full_frame();
        test_points();
        test_cfg_midframe();
        test_cfg_coincident();
        test_clip();
        test_enable_drop();
        test_reset_midframe();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
